// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source: N pulses of H cycles high separated by L-cycle gaps,
// with a one-cycle done strobe on normal completion and synchronous abort.
module pulse_train_generator #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] high_len,
   input  logic [LEN_W-1:0] low_len,
   input  logic [CNT_W-1:0] pulse_cnt,
   output logic             pulse,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

   state_t           state;
   state_t           next_state;
   logic [LEN_W-1:0] h_m1;
   logic [LEN_W-1:0] l_m1;
   logic [LEN_W-1:0] phase_cnt;
   logic [CNT_W-1:0] remaining;
   logic [LEN_W-1:0] high_m1_in;
   logic [LEN_W-1:0] low_m1_in;
   logic             accept;
   logic             phase_end;
   logic             pulse_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // Lengths are stored minus one so a zero request collapses onto a one-cycle phase.
   assign high_m1_in = (high_len == '0) ? '0 : high_len - LEN_W'(1);
   assign low_m1_in  = (low_len == '0) ? '0 : low_len - LEN_W'(1);
   assign accept     = (state == IDLE) && start && !abort;
   assign phase_end  = (phase_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               next_state = (pulse_cnt == '0) ? DONE : HIGH;
            end
         end
         HIGH: begin
            if (abort) begin
               next_state = IDLE;
            end else if (phase_end) begin
               next_state = (remaining == '0) ? DONE : LOW;
            end
         end
         LOW: begin
            if (abort) begin
               next_state = IDLE;
            end else if (phase_end) begin
               next_state = HIGH;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Phase counter runs down to zero in each phase; remaining counts pulses still to emit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_m1      <= '0;
         l_m1      <= '0;
         phase_cnt <= '0;
         remaining <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  h_m1      <= high_m1_in;
                  l_m1      <= low_m1_in;
                  phase_cnt <= high_m1_in;
                  remaining <= (pulse_cnt == '0) ? '0 : pulse_cnt - CNT_W'(1);
               end
            end
            HIGH: begin
               if (phase_end) begin
                  phase_cnt <= l_m1;
                  if (remaining != '0) begin
                     remaining <= remaining - CNT_W'(1);
                  end
               end else begin
                  phase_cnt <= phase_cnt - LEN_W'(1);
               end
            end
            LOW: begin
               if (phase_end) begin
                  phase_cnt <= h_m1;
               end else begin
                  phase_cnt <= phase_cnt - LEN_W'(1);
               end
            end
            default: begin
               phase_cnt <= '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the upcoming state and registered, so they change with the state.
   always_comb begin
      pulse_nxt = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      unique case (next_state)
         HIGH: begin
            pulse_nxt = 1'b1;
            busy_nxt  = 1'b1;
         end
         LOW: begin
            busy_nxt = 1'b1;
         end
         DONE: begin
            done_nxt = 1'b1;
         end
         default: begin
            pulse_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         pulse <= pulse_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: expected waveforms come from the N/H/L timing formula.
module tb_pulse_train_generator;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [7:0] high_len;
   logic [7:0] low_len;
   logic [7:0] pulse_cnt;
   logic       pulse;
   logic       busy;
   logic       done;

   int total_checks;
   int passed_checks;

   pulse_train_generator #(.LEN_W(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .high_len  (high_len),
      .low_len   (low_len),
      .pulse_cnt (pulse_cnt),
      .pulse     (pulse),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic [7:0] h,
                                input logic [7:0] l, input logic [7:0] n);
      start     = s;
      abort     = a;
      high_len  = h;
      low_len   = l;
      pulse_cnt = n;
   endtask

   task automatic checkValue(input string tag, input int observed, input int expected);
      total_checks++;
      assert (observed === expected) begin
         passed_checks++;
      end else begin
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag, input logic ep, input logic eb, input logic ed);
      checkValue({tag, ".pulse"}, int'(pulse), int'(ep));
      checkValue({tag, ".busy"}, int'(busy), int'(eb));
      checkValue({tag, ".done"}, int'(done), int'(ed));
   endtask

   // Caller leaves start=1 with the config; cycle c is the c-th cycle after the accepting edge.
   task automatic expectTrain(input string tag, input int h, input int l, input int n,
                              input int disturb_at, input int abort_at);
      int  hc;
      int  lc;
      int  total;
      int  edges;
      logic prev;
      hc    = (h == 0) ? 1 : h;
      lc    = (l == 0) ? 1 : l;
      total = (n == 0) ? 0 : n * hc + (n - 1) * lc;
      edges = 0;
      prev  = 1'b0;
      for (int c = 1; c <= total; c++) begin
         step();
         if (c == 1 || c == disturb_at + 1) begin
            applyStimulus(1'b0, 1'b0, 8'd1, 8'd1, 8'd9);
         end
         checkOutput($sformatf("%s.c%0d", tag, c), ((c - 1) % (hc + lc)) < hc, 1'b1, 1'b0);
         if (pulse && !prev) edges++;
         prev = pulse;
         if (c == disturb_at) begin
            applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 8'd9);
         end
         if (c == abort_at) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            for (int j = 0; j < 4; j++) begin
               checkOutput($sformatf("%s.aborted%0d", tag, j), 1'b0, 1'b0, 1'b0);
               step();
            end
            return;
         end
      end
      step();
      if (total == 0) start = 1'b0;
      checkOutput({tag, ".done"}, 1'b0, 1'b0, 1'b1);
      step();
      checkOutput({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
      checkValue({tag, ".edges"}, edges, n);
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      step();
      checkOutput("reset", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      checkOutput("post_reset", 1'b0, 1'b0, 1'b0);

      $display("[TB] basic train H=2 L=3 N=3");
      applyStimulus(1'b1, 1'b0, 8'd2, 8'd3, 8'd3);
      expectTrain("basic", 2, 3, 3, 0, 0);

      $display("[TB] zero-length clamp N=4");
      applyStimulus(1'b1, 1'b0, 8'd0, 8'd0, 8'd4);
      expectTrain("clamp", 0, 0, 4, 0, 0);

      $display("[TB] empty train");
      applyStimulus(1'b1, 1'b0, 8'd5, 8'd5, 8'd0);
      expectTrain("empty", 5, 5, 0, 0, 0);

      $display("[TB] start during train ignored");
      applyStimulus(1'b1, 1'b0, 8'd4, 8'd4, 8'd2);
      expectTrain("ignored", 4, 4, 2, 3, 0);

      $display("[TB] abort in second gap");
      applyStimulus(1'b1, 1'b0, 8'd2, 8'd2, 8'd5);
      expectTrain("abort", 2, 2, 5, 0, 7);

      $display("[TB] start with abort in idle");
      applyStimulus(1'b1, 1'b1, 8'd2, 8'd2, 8'd2);
      for (int j = 0; j < 3; j++) begin
         step();
         checkOutput($sformatf("start_abort%0d", j), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      step();

      $display("[TB] asynchronous reset mid-train");
      applyStimulus(1'b1, 1'b0, 8'd6, 8'd1, 8'd2);
      step();
      start = 1'b0;
      step();
      checkOutput("pre_rst", 1'b1, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst", 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      step();
      checkOutput("after_rst", 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd3, 8'd1, 8'd2);
      expectTrain("restart", 3, 1, 2, 0, 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
